// File: rtl/rr_bus_arbiter_pkg.sv
// arbiter_pkg: shared FSM state type and round-robin mask helper for rr_bus_arbiter.
package arbiter_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, GRANTED = 1'b1} state_t;
  function automatic logic mask_bit(input int idx, input int pos, input bit lsb_high);
    return lsb_high ? (pos > idx) : (pos < idx);
  endfunction
endpackage

// File: rtl/rr_bus_arbiter_if.sv
// rr_bus_arbiter_if: request/grant bus; lock signal exists only with ARBITER_LOCK_EN.
interface rr_bus_arbiter_if #(parameter int PORTS = 4);
  logic [PORTS-1:0] request;
  logic [PORTS-1:0] acknowledge;
`ifdef ARBITER_LOCK_EN
  logic [PORTS-1:0] lock;
`endif
  logic [PORTS-1:0] grant;
  logic grant_valid;
  logic [$clog2(PORTS)-1:0] grant_encoded;
  modport master (
`ifdef ARBITER_LOCK_EN
    output lock,
`endif
    output request, acknowledge,
    input grant, grant_valid, grant_encoded
  );
  modport slave (
`ifdef ARBITER_LOCK_EN
    input lock,
`endif
    input request, acknowledge,
    output grant, grant_valid, grant_encoded
  );
endinterface

// File: rtl/rr_bus_arbiter_priority_encoder.sv
// priority_encoder: picks lowest (or highest) set bit, reports index and one-hot form.
module priority_encoder #(
  parameter int WIDTH = 4,
  parameter int LSB_HIGH_PRIORITY = 1
) (
  input  logic [WIDTH-1:0]         input_unencoded,
  output logic                     output_valid,
  output logic [$clog2(WIDTH)-1:0] output_encoded,
  output logic [WIDTH-1:0]         output_unencoded
);
  localparam int EW = $clog2(WIDTH);
  assign output_valid = |input_unencoded;
  assign output_unencoded = output_valid ? ({{(WIDTH-1){1'b0}}, 1'b1} << output_encoded) : '0;
  // Scan from the low-priority end so the last hit is the winner.
  always_comb begin
    output_encoded = '0;
    for (int i = 0; i < WIDTH; i++)
      if (input_unencoded[(LSB_HIGH_PRIORITY != 0) ? WIDTH-1-i : i])
        output_encoded = EW'((LSB_HIGH_PRIORITY != 0) ? WIDTH-1-i : i);
  end
endmodule

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: registered round-robin/fixed-priority arbiter, one grant outstanding.
// Optional ARBITER_LOCK_EN: lock[g] holds the current grant against release.
module rr_bus_arbiter
  import arbiter_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int ARB_RR = 1,
  parameter int LSB_HIGH_PRIORITY = 1
) (
  input logic clk,
  input logic rst,
  rr_bus_arbiter_if.slave bus
);
  localparam int EW = $clog2(PORTS);
  state_t state;
  logic [PORTS-1:0] mask, mask_n, m_onehot, u_onehot, win_onehot;
  logic [EW-1:0] m_enc, u_enc, win_enc;
  logic m_valid, u_valid, rel;
  priority_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)) u_masked (
    .input_unencoded(bus.request & mask),
    .output_valid(m_valid),
    .output_encoded(m_enc),
    .output_unencoded(m_onehot)
  );
  priority_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)) u_unmasked (
    .input_unencoded(bus.request),
    .output_valid(u_valid),
    .output_encoded(u_enc),
    .output_unencoded(u_onehot)
  );
  always_comb begin
    win_enc = ((ARB_RR != 0) && m_valid) ? m_enc : u_enc;
    win_onehot = ((ARB_RR != 0) && m_valid) ? m_onehot : u_onehot;
    for (int i = 0; i < PORTS; i++) mask_n[i] = mask_bit(int'(win_enc), i, LSB_HIGH_PRIORITY != 0);
  end
`ifdef ARBITER_LOCK_EN
  assign rel = (bus.acknowledge[bus.grant_encoded] | ~bus.request[bus.grant_encoded]) & ~bus.lock[bus.grant_encoded];
`else
  assign rel = bus.acknowledge[bus.grant_encoded] | ~bus.request[bus.grant_encoded];
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mask <= '1;
      bus.grant <= '0;
      bus.grant_valid <= 1'b0;
      bus.grant_encoded <= '0;
    end else if (state == IDLE) begin
      if (u_valid) begin
        state <= GRANTED;
        mask <= mask_n;
        bus.grant <= win_onehot;
        bus.grant_valid <= 1'b1;
        bus.grant_encoded <= win_enc;
      end
    end else if (rel) begin
      state <= IDLE;
      bus.grant <= '0;
      bus.grant_valid <= 1'b0;
      bus.grant_encoded <= '0;
    end
  end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: directed checks on round-robin and both fixed-priority builds.
module tb_rr_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0, ack = '0, ack_fp = '0, ack_fm = '0, lck = '0;
  int n_cmp = 0, n_err = 0;
  rr_bus_arbiter_if #(.PORTS(4)) bus ();
  rr_bus_arbiter_if #(.PORTS(4)) bus_fp ();
  rr_bus_arbiter_if #(.PORTS(4)) bus_fm ();
  assign bus.request = req;
  assign bus_fp.request = req;
  assign bus_fm.request = req;
  assign bus.acknowledge = ack;
  assign bus_fp.acknowledge = ack_fp;
  assign bus_fm.acknowledge = ack_fm;
`ifdef ARBITER_LOCK_EN
  assign bus.lock = lck;
  assign bus_fp.lock = '0;
  assign bus_fm.lock = '0;
`endif
  rr_bus_arbiter #(.PORTS(4), .ARB_RR(1), .LSB_HIGH_PRIORITY(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  rr_bus_arbiter #(.PORTS(4), .ARB_RR(0), .LSB_HIGH_PRIORITY(1)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));
  rr_bus_arbiter #(.PORTS(4), .ARB_RR(0), .LSB_HIGH_PRIORITY(0)) dut_fm (.clk(clk), .rst(rst), .bus(bus_fm));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    chk("idle_grant", 32'(bus.grant), 32'h0);
    chk("idle_valid", 32'(bus.grant_valid), 32'h0);
    chk("idle_enc", 32'(bus.grant_encoded), 32'h0);
    req = 4'b0110;
    step();
    chk("t2_grant", 32'(bus.grant), 32'b0010);
    chk("t2_enc", 32'(bus.grant_encoded), 32'd1);
    chk("t2_valid", 32'(bus.grant_valid), 32'd1);
    step();
    chk("t2_hold", 32'(bus.grant), 32'b0010);
    ack = 4'b0010;
    step();
    ack = '0;
    chk("t2_release", 32'(bus.grant), 32'h0);
    chk("t2_rel_valid", 32'(bus.grant_valid), 32'h0);
    step();
    chk("t2_next_grant", 32'(bus.grant), 32'b0100);
    chk("t2_next_enc", 32'(bus.grant_encoded), 32'd2);
    ack = 4'b0001;
    step();
    ack = '0;
    chk("t5_foreign_ack", 32'(bus.grant), 32'b0100);
    req = 4'b1011;
    step();
    chk("t5_req_drop", 32'(bus.grant), 32'h0);
    step();
    chk("t5_rr_after_drop", 32'(bus.grant), 32'b1000);
    chk("t5_rr_enc", 32'(bus.grant_encoded), 32'd3);
    ack = 4'b1000;
    step();
    ack = '0;
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_rr_%0d", k), 32'(bus.grant), 32'(rr_seq[k]));
      ack = rr_seq[k];
      step();
      ack = '0;
      chk($sformatf("t3_gap_%0d", k), 32'(bus.grant), 32'h0);
      if (k < 4) step();
    end
    step();
    chk("t1_pre_reset", 32'(bus.grant), 32'b0010);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_grant", 32'(bus.grant), 32'h0);
    chk("t1_async_valid", 32'(bus.grant_valid), 32'h0);
    chk("t1_async_enc", 32'(bus.grant_encoded), 32'h0);
    rst = 1'b0;
    step();
    chk("t1_post_reset", 32'(bus.grant), 32'b0001);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_lsb_%0d", k), 32'(bus_fp.grant), 32'b0001);
      chk($sformatf("t4_msb_%0d", k), 32'(bus_fm.grant), 32'b1000);
      chk($sformatf("t4_msb_enc_%0d", k), 32'(bus_fm.grant_encoded), 32'd3);
      ack_fp = 4'b0001;
      ack_fm = 4'b1000;
      step();
      ack_fp = '0;
      ack_fm = '0;
      chk($sformatf("t4_lsb_gap_%0d", k), 32'(bus_fp.grant), 32'h0);
      step();
    end
`ifdef ARBITER_LOCK_EN
    chk("t6_start", 32'(bus.grant), 32'b0001);
    lck = 4'b0001;
    ack = 4'b0001;
    step();
    chk("t6_locked", 32'(bus.grant), 32'b0001);
    lck = '0;
    step();
    ack = '0;
    chk("t6_unlocked", 32'(bus.grant), 32'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
